snoop_bus_controller: RTL and testbench
=======================================

Name: snoop_bus_controller

Overview:
- Upstream sequencer and shared-bus arbiter for the MSI snooping caches.
- Accepts one 9-bit processor instruction at a time and drives the common step/instruction lines through the four bus phases 0..3.
- Merges every cache's bus_out into the single registered bus_in they snoop, and owns the 4-entry x 4-bit main memory that supplies read-miss data and absorbs write-backs.
- Keeps saturating transaction counters.

Parameters:
N_CPU, 3, number of attached caches; cache i carries NAME i (valid range 1..3).
READ_MISS, 2'd1, bus message type for a read miss.
READ_HIT, 2'd2, bus message type for a read hit; also the idle type.
WRITE_BACK, 2'd3, bus message type for a write-back.
MEM_INIT, 16'h0000, reset image of main memory; entry a = MEM_INIT[4a+3:4a].

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  new instruction offered
instr_in  in  9  {op, cpu[1:0], tag[1:0], value[3:0]}; op 0 = LOAD, 1 = STORE
instr_ready  out  1  controller can take instr_in this cycle
step  out  2  bus phase broadcast to all caches
instruction  out  9  latched instruction broadcast to all caches
cache_bus  in  8*N_CPU  bus_out of cache i in bits [8i+7:8i]; each is {type[1:0], tag[1:0], value[3:0]}
bus_in  out  8  resolved, registered bus value to all caches
done  out  1  one-cycle pulse when an instruction's phase 3 completes
rm_count  out  8  read misses seen, saturating at 255
wb_count  out  8  write-backs absorbed, saturating at 255
inv_count  out  8  invalidates seen (type 2'd0 in phase 1), saturating at 255
dbg_addr  in  2  memory probe address
dbg_data  out  4  combinational read of mem[dbg_addr]

Behaviour:
- Reset values (asynchronous, rst_n low):
  - FSM = IDLE, step = 2'b11.
  - instruction = 9'h0C0 (LOAD by cpu 3, which addresses no cache).
  - bus_in = {READ_HIT, 2'b00, 4'h0}.
  - done = 0, all counters = 0, memory = MEM_INIT.
- FSM has two states, IDLE and RUN.
- instr_ready = (state == IDLE) || (state == RUN && step == 3).
- Accept = instr_valid && instr_ready. On accept:
  - instruction <= instr_in, step <= 0, state <= RUN.
- In RUN, step advances by 1 every cycle, giving exactly 4 cycles per instruction and back-to-back throughput of 1 instruction per 4 cycles.
- At the end of the step-3 cycle:
  - done pulses high for the next cycle.
  - With no accept: state <= IDLE and step holds at 3, so step changes only when a new instruction starts.
- Resolution runs each cycle over the cache_bus slices:
  - A slice is active when its type != READ_HIT.
  - Winner = lowest-index WRITE_BACK slice. If there is none, winner = lowest-index active slice. If there is none, the bus is idle.
- bus_in and memory updates are registered at the end of each RUN phase:
  - Phase 0 end: if the winner is WRITE_BACK, mem[tag] <= value and wb_count++. bus_in <= idle.
  - Phase 1 end: req <= winner (idle if none) and bus_in <= req. Type READ_MISS → rm_count++. Type 2'd0 (invalidate) → inv_count++.
  - Phase 2 end: if the winner is WRITE_BACK, mem[tag] <= value and wb_count++. If req type == READ_MISS, bus_in <= {READ_MISS, req.tag, d}, where d = the write-back value if one occurred this phase, else mem[req.tag] (pre-update read is never used). Otherwise bus_in <= idle.
  - Phase 3 end: bus_in <= idle.
- Counters saturate at 255 and never wrap.
- Multiple WRITE_BACK slices in one phase: the lowest index wins, and the counter increments once.
- A reset asserted mid-instruction aborts it immediately. Memory returns to MEM_INIT. No done pulse is produced.
- instruction and bus_in change only on clock edges; no combinational path runs from cache_bus to bus_in.

Test Plan:
1. Reset with MEM_INIT=16'h4321, then LOAD cpu1 tag2 (instr_in=9'h060). All caches answer idle in phase 0; cache1 sends {READ_MISS,2,0} in phase 1. Required: bus_in in phase 3 = {READ_MISS,2'd2,4'h3}, rm_count=1, done exactly 4 cycles after accept.
2. STORE cpu0 tag1 value 9 (9'h119). Cache0 sends {0,1,0} in phase 1; cache2 sends {WRITE_BACK,1,4'h7} in phase 2. Required: inv_count=1, wb_count=1, mem[1]=7 via dbg_addr=1, bus_in idle in phase 3.
3. Read miss with owner. Cache2 sends {READ_MISS,0,0} in phase 1; cache1 sends {WRITE_BACK,0,4'hA} in phase 2 while mem[0]=1. Required: phase-3 bus_in = {READ_MISS,0,4'hA} and mem[0]=A.
4. Phase-0 eviction. Cache0 sends {WRITE_BACK,3,4'h5} in phase 0. Required: mem[3]=5 and phase-1 bus_in idle. Simultaneously cache1 and cache2 send WRITE_BACK in phase 2 → cache1's value is taken and wb_count increments by 1.
5. Hold instr_valid high for 3 instructions. Required: instr_ready high only on step==3 cycles, accepts exactly 4 cycles apart, step sequence 0,1,2,3,0,1,2,3,... Drive 300 read misses → rm_count stays at 255.
6. Drop rst_n during phase 2. Required: step=3, bus_in={READ_HIT,0,0}, instruction=9'h0C0 and counters=0 asynchronously; no done pulse; the next accept starts at phase 0.

Source files
------------

// File: rtl/snoop_bus_controller.sv
// rtl/snoop_bus_controller.sv - MSI snoop bus sequencer, arbiter and main memory
module snoop_bus_controller #(
    parameter int          N_CPU      = 3,
    parameter logic [1:0]  READ_MISS  = 2'd1,
    parameter logic [1:0]  READ_HIT   = 2'd2,
    parameter logic [1:0]  WRITE_BACK = 2'd3,
    parameter logic [15:0] MEM_INIT   = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    input  logic [8:0]           instr_in,
    output logic                 instr_ready,
    output logic [1:0]           step,
    output logic [8:0]           instruction,
    input  logic [8*N_CPU-1:0]   cache_bus,
    output logic [7:0]           bus_in,
    output logic                 done,
    output logic [7:0]           rm_count,
    output logic [7:0]           wb_count,
    output logic [7:0]           inv_count,
    input  logic [1:0]           dbg_addr,
    output logic [3:0]           dbg_data
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [7:0] IDLE_WORD = {READ_HIT, 6'h00};

    state_t     state, state_next;
    logic       accept;
    logic [3:0] mem [4];
    logic [7:0] req;
    logic       wb_hit;
    logic [7:0] wb_word, act_word, winner;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (step == 2'd3 && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        instr_ready = (state == IDLE) || (state == RUN && step == 2'd3);
    end

    assign accept   = instr_valid && instr_ready;
    assign dbg_data = mem[dbg_addr];

    // Descending scan so the lowest-index match is the one left standing.
    always_comb begin
        wb_hit   = 1'b0;
        wb_word  = IDLE_WORD;
        act_word = IDLE_WORD;
        for (int i = N_CPU - 1; i >= 0; i--) begin
            if (cache_bus[8*i+6 +: 2] == WRITE_BACK) begin
                wb_hit  = 1'b1;
                wb_word = cache_bus[8*i +: 8];
            end
            if (cache_bus[8*i+6 +: 2] != READ_HIT) act_word = cache_bus[8*i +: 8];
        end
        winner = wb_hit ? wb_word : act_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step        <= 2'd3;
            instruction <= 9'h0C0;
            bus_in      <= IDLE_WORD;
            req         <= IDLE_WORD;
            done        <= 1'b0;
            rm_count    <= 8'd0;
            wb_count    <= 8'd0;
            inv_count   <= 8'd0;
            for (int a = 0; a < 4; a++) mem[a] <= MEM_INIT[4*a +: 4];
        end else begin
            done <= 1'b0;
            if (accept) begin
                instruction <= instr_in;
                step        <= 2'd0;
            end else if (state == RUN && step != 2'd3) begin
                step <= step + 2'd1;
            end
            if (state == RUN) begin
                case (step)
                    2'd0: begin
                        if (wb_hit) begin
                            mem[wb_word[5:4]] <= wb_word[3:0];
                            wb_count          <= sat_inc(wb_count);
                        end
                        bus_in <= IDLE_WORD;
                    end
                    2'd1: begin
                        req    <= winner;
                        bus_in <= winner;
                        if (winner[7:6] == READ_MISS) rm_count  <= sat_inc(rm_count);
                        if (winner[7:6] == 2'd0)      inv_count <= sat_inc(inv_count);
                    end
                    2'd2: begin
                        if (wb_hit) begin
                            mem[wb_word[5:4]] <= wb_word[3:0];
                            wb_count          <= sat_inc(wb_count);
                        end
                        // An owner's write-back this phase supersedes stale memory.
                        if (req[7:6] == READ_MISS)
                            bus_in <= {READ_MISS, req[5:4], wb_hit ? wb_word[3:0] : mem[req[5:4]]};
                        else
                            bus_in <= IDLE_WORD;
                    end
                    default: begin
                        bus_in <= IDLE_WORD;
                        done   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snoop_bus_controller.sv
// tb/tb_snoop_bus_controller.sv - directed self-checking bench for snoop_bus_controller
module tb_snoop_bus_controller;

    localparam logic [7:0] IDL = 8'h80;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [8:0]  instr_in;
    logic        instr_ready;
    logic [1:0]  step;
    logic [8:0]  instruction;
    logic [23:0] cache_bus;
    logic [7:0]  bus_in;
    logic        done;
    logic [7:0]  rm_count, wb_count, inv_count;
    logic [1:0]  dbg_addr;
    logic [3:0]  dbg_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    snoop_bus_controller #(.MEM_INIT(16'h4321)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_in(instr_in),
        .instr_ready(instr_ready), .step(step), .instruction(instruction),
        .cache_bus(cache_bus), .bus_in(bus_in), .done(done),
        .rm_count(rm_count), .wb_count(wb_count), .inv_count(inv_count),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    task automatic test_reset();
        logic [3:0] exp_mem [4];
        exp_mem[0] = 4'h1; exp_mem[1] = 4'h2; exp_mem[2] = 4'h3; exp_mem[3] = 4'h4;
        rst_n = 1'b0; instr_valid = 1'b0; instr_in = 9'h0; cache_bus = {IDL, IDL, IDL}; dbg_addr = 2'd0;
        @(negedge clk); @(negedge clk);
        checks++; if (step !== 2'd3) begin errors++; $display("FAIL reset_step got %0d want 3", step); end
        checks++; if (instruction !== 9'h0C0) begin errors++; $display("FAIL reset_instr got %h want 0c0", instruction); end
        checks++; if (bus_in !== IDL) begin errors++; $display("FAIL reset_bus got %h want 80", bus_in); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if ({rm_count, wb_count, inv_count} !== 24'h0) begin errors++; $display("FAIL reset_counters got %h want 0", {rm_count, wb_count, inv_count}); end
        for (int a = 0; a < 4; a++) begin
            dbg_addr = a[1:0]; #1;
            checks++; if (dbg_data !== exp_mem[a]) begin errors++; $display("FAIL reset_mem%0d got %h want %h", a, dbg_data, exp_mem[a]); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_read_miss();
        @(negedge clk);
        checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b want 1", instr_ready); end
        instr_valid = 1'b1; instr_in = 9'h060;
        @(negedge clk); instr_valid = 1'b0;
        checks++; if (step !== 2'd0 || instruction !== 9'h060) begin errors++; $display("FAIL rm_start got step %0d instr %h want 0 060", step, instruction); end
        @(negedge clk); cache_bus = {IDL, 8'h60, IDL};
        @(negedge clk); cache_bus = {IDL, IDL, IDL};
        @(negedge clk);
        checks++; if (bus_in !== 8'h63) begin errors++; $display("FAIL rm_bus got %h want 63", bus_in); end
        checks++; if (rm_count !== 8'd1) begin errors++; $display("FAIL rm_count got %0d want 1", rm_count); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rm_done_early got %b want 0", done); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || step !== 2'd3) begin errors++; $display("FAIL rm_done got %b step %0d want 1 3", done, step); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rm_done_pulse got %b want 0", done); end
    endtask

    task automatic test_store_invalidate();
        @(negedge clk); instr_valid = 1'b1; instr_in = 9'h119;
        @(negedge clk); instr_valid = 1'b0;
        @(negedge clk); cache_bus = {IDL, IDL, 8'h10};
        @(negedge clk); cache_bus = {8'hD7, IDL, IDL};
        @(negedge clk); cache_bus = {IDL, IDL, IDL}; dbg_addr = 2'd1; #1;
        checks++; if (inv_count !== 8'd1) begin errors++; $display("FAIL st_inv got %0d want 1", inv_count); end
        checks++; if (wb_count !== 8'd1) begin errors++; $display("FAIL st_wb got %0d want 1", wb_count); end
        checks++; if (dbg_data !== 4'h7) begin errors++; $display("FAIL st_mem1 got %h want 7", dbg_data); end
        checks++; if (bus_in !== IDL) begin errors++; $display("FAIL st_bus got %h want 80", bus_in); end
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_owner_supply();
        @(negedge clk); instr_valid = 1'b1; instr_in = 9'h080;
        @(negedge clk); instr_valid = 1'b0;
        @(negedge clk); cache_bus = {8'h40, IDL, IDL};
        @(negedge clk); cache_bus = {IDL, 8'hCA, IDL};
        @(negedge clk); cache_bus = {IDL, IDL, IDL}; dbg_addr = 2'd0; #1;
        checks++; if (bus_in !== 8'h4A) begin errors++; $display("FAIL own_bus got %h want 4a", bus_in); end
        checks++; if (dbg_data !== 4'hA) begin errors++; $display("FAIL own_mem0 got %h want a", dbg_data); end
        checks++; if (rm_count !== 8'd2) begin errors++; $display("FAIL own_rm got %0d want 2", rm_count); end
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_eviction();
        @(negedge clk); instr_valid = 1'b1; instr_in = 9'h135;
        @(negedge clk); instr_valid = 1'b0; cache_bus = {IDL, IDL, 8'hF5};
        @(negedge clk); cache_bus = {IDL, IDL, IDL}; dbg_addr = 2'd3; #1;
        checks++; if (dbg_data !== 4'h5) begin errors++; $display("FAIL ev_mem3 got %h want 5", dbg_data); end
        checks++; if (bus_in !== IDL) begin errors++; $display("FAIL ev_bus1 got %h want 80", bus_in); end
        checks++; if (wb_count !== 8'd3) begin errors++; $display("FAIL ev_wb0 got %0d want 3", wb_count); end
        @(negedge clk); cache_bus = {8'hE1, 8'hEC, IDL};
        @(negedge clk); cache_bus = {IDL, IDL, IDL}; dbg_addr = 2'd2; #1;
        checks++; if (dbg_data !== 4'hC) begin errors++; $display("FAIL ev_mem2 got %h want c", dbg_data); end
        checks++; if (wb_count !== 8'd4) begin errors++; $display("FAIL ev_wb2 got %0d want 4", wb_count); end
        checks++; if (bus_in !== IDL) begin errors++; $display("FAIL ev_bus3 got %h want 80", bus_in); end
        @(negedge clk); @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int es;
        int exp_rm = 2;
        @(negedge clk);
        instr_valid = 1'b1; instr_in = 9'h060; cache_bus = {IDL, 8'h60, IDL};
        for (int k = 0; k <= 1200; k++) begin
            if (k > 0) @(negedge clk);
            es = (k == 0) ? 3 : (k - 1) % 4;
            checks++; if (step !== es[1:0]) begin errors++; $display("FAIL b2b_step k=%0d got %0d want %0d", k, step, es); end
            checks++; if (instr_ready !== (es == 3)) begin errors++; $display("FAIL b2b_ready k=%0d got %b want %b", k, instr_ready, es == 3); end
            checks++; if (done !== (k >= 5 && es == 0)) begin errors++; $display("FAIL b2b_done k=%0d got %b want %b", k, done, k >= 5 && es == 0); end
            if (es == 2) begin
                exp_rm = (exp_rm == 255) ? 255 : exp_rm + 1;
                checks++; if (rm_count !== exp_rm[7:0]) begin errors++; $display("FAIL b2b_rm k=%0d got %0d want %0d", k, rm_count, exp_rm); end
            end
        end
        instr_valid = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b1 || step !== 2'd3) begin errors++; $display("FAIL b2b_last got done %b step %0d want 1 3", done, step); end
        checks++; if (rm_count !== 8'd255) begin errors++; $display("FAIL b2b_sat got %0d want 255", rm_count); end
        cache_bus = {IDL, IDL, IDL};
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        @(negedge clk); instr_valid = 1'b1; instr_in = 9'h060;
        @(negedge clk); instr_valid = 1'b0;
        @(negedge clk); cache_bus = {IDL, 8'h60, IDL};
        @(negedge clk); cache_bus = {IDL, IDL, IDL}; dbg_addr = 2'd3;
        rst_n = 1'b0; #1;
        checks++; if (step !== 2'd3) begin errors++; $display("FAIL ab_step got %0d want 3", step); end
        checks++; if (bus_in !== IDL) begin errors++; $display("FAIL ab_bus got %h want 80", bus_in); end
        checks++; if (instruction !== 9'h0C0) begin errors++; $display("FAIL ab_instr got %h want 0c0", instruction); end
        checks++; if ({rm_count, wb_count, inv_count} !== 24'h0) begin errors++; $display("FAIL ab_counters got %h want 0", {rm_count, wb_count, inv_count}); end
        checks++; if (dbg_data !== 4'h4) begin errors++; $display("FAIL ab_mem3 got %h want 4", dbg_data); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ab_done got %b want 0", done); end
        rst_n = 1'b1; instr_valid = 1'b1; instr_in = 9'h119;
        @(negedge clk); instr_valid = 1'b0;
        checks++; if (step !== 2'd0 || done !== 1'b0) begin errors++; $display("FAIL ab_restart got step %0d done %b want 0 0", step, done); end
        @(negedge clk);
        checks++; if (step !== 2'd1) begin errors++; $display("FAIL ab_step1 got %0d want 1", step); end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_store_invalidate();
        test_owner_supply();
        test_eviction();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
